// File: rtl/icb_dbg_arb_pkg.sv
// Shared IDs, default bus widths and the tie-break helper for the ICB debug arbiter.
package icb_dbg_arb_pkg;

   localparam int unsigned MEM_ADDR_W = 32;
   localparam int unsigned MEM_DATA_W = 32;

   typedef logic arb_id_t;

   localparam arb_id_t ARB_ID_CORE = 1'b0;
   localparam arb_id_t ARB_ID_JTAG = 1'b1;

   // Picks a master from the valid pair; tie_win decides when both request.
   function automatic arb_id_t arb_pick(input logic v0, input logic v1, input arb_id_t tie_win);
      arb_id_t id;
      id = ARB_ID_CORE;
      if (v0 && v1) begin
         id = tie_win;
      end else if (v1) begin
         id = ARB_ID_JTAG;
      end
      return id;
   endfunction

endpackage

// File: rtl/icb_dbg_arb_ost_fifo.sv
// Outstanding-command ID FIFO: one bit per entry naming the master that owns each
// in-flight command, so responses can be steered back in issue order.
module icb_dbg_arb_ost_fifo #(
   parameter int unsigned DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic                         push_id_i,
   input  logic                         pop_i,
   output logic                         head_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   // Explicit wrap keeps a depth of one legal (pointer then never moves).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign head_o  = mem_q[rd_ptr_q];
   assign cnt_o   = cnt_q;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_id_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/icb_dbg_arb.sv
// 2:1 ICB arbiter sharing one memory-side slave port between core LSU (m0) and JTAG (m1).
// Define ICB_ARB_RR_EN for round-robin; otherwise fixed priority with m1 over m0.
module icb_dbg_arb
   import icb_dbg_arb_pkg::*;
#(
   parameter int unsigned AW        = MEM_ADDR_W,
   parameter int unsigned DW        = MEM_DATA_W,
   parameter int unsigned OST_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              m0_icb_cmd_valid,
   output logic              m0_icb_cmd_ready,
   input  logic [AW-1:0]     m0_icb_cmd_addr,
   input  logic              m0_icb_cmd_read,
   input  logic [DW-1:0]     m0_icb_cmd_wdata,
   input  logic [DW/8-1:0]   m0_icb_cmd_wmask,
   output logic              m0_icb_rsp_valid,
   input  logic              m0_icb_rsp_ready,
   output logic              m0_icb_rsp_err,
   output logic [DW-1:0]     m0_icb_rsp_rdata,

   input  logic              m1_icb_cmd_valid,
   output logic              m1_icb_cmd_ready,
   input  logic [AW-1:0]     m1_icb_cmd_addr,
   input  logic              m1_icb_cmd_read,
   input  logic [DW-1:0]     m1_icb_cmd_wdata,
   input  logic [DW/8-1:0]   m1_icb_cmd_wmask,
   output logic              m1_icb_rsp_valid,
   input  logic              m1_icb_rsp_ready,
   output logic              m1_icb_rsp_err,
   output logic [DW-1:0]     m1_icb_rsp_rdata,

   output logic              s_icb_cmd_valid,
   input  logic              s_icb_cmd_ready,
   output logic [AW-1:0]     s_icb_cmd_addr,
   output logic              s_icb_cmd_read,
   output logic [DW-1:0]     s_icb_cmd_wdata,
   output logic [DW/8-1:0]   s_icb_cmd_wmask,
   input  logic              s_icb_rsp_valid,
   output logic              s_icb_rsp_ready,
   input  logic              s_icb_rsp_err,
   input  logic [DW-1:0]     s_icb_rsp_rdata,

   output logic              arb_err_o
);

   localparam int unsigned CW = $clog2(OST_DEPTH + 1);

   logic          live;
   arb_id_t       grant, pick, tie_win;
   logic          sel_valid;
   logic          lock_q, lock_d;
   arb_id_t       lock_id_q, lock_id_d;
   logic          arb_err_q, arb_err_d;
   logic          ost_full, ost_empty, fifo_full;
   arb_id_t       head;
   logic [CW-1:0] ost_cnt;
   logic          head_rsp_ready;
   logic          cmd_hs, rsp_hs;

   // Every output is forced low while reset is asserted, including the combinational ones.
   assign live = rst_n;

`ifdef ICB_ARB_RR_EN
   arb_id_t rr_last_q, rr_last_d;

   assign tie_win   = ~rr_last_q;
   assign rr_last_d = cmd_hs ? grant : rr_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last_q <= ARB_ID_CORE;
      end else begin
         rr_last_q <= rr_last_d;
      end
   end
`else
   assign tie_win = ARB_ID_JTAG;
`endif

   // A presented-but-unaccepted command pins the grant so its payload cannot switch.
   assign pick      = arb_pick(m0_icb_cmd_valid, m1_icb_cmd_valid, tie_win);
   assign grant     = lock_q ? lock_id_q : pick;
   assign sel_valid = (grant == ARB_ID_JTAG) ? m1_icb_cmd_valid : m0_icb_cmd_valid;
   assign ost_full  = (ost_cnt == CW'(OST_DEPTH));

   assign s_icb_cmd_valid  = live & sel_valid & ~ost_full;
   assign s_icb_cmd_addr   = !live ? '0 : (grant == ARB_ID_JTAG) ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
   assign s_icb_cmd_read   = live & ((grant == ARB_ID_JTAG) ? m1_icb_cmd_read : m0_icb_cmd_read);
   assign s_icb_cmd_wdata  = !live ? '0 : (grant == ARB_ID_JTAG) ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
   assign s_icb_cmd_wmask  = !live ? '0 : (grant == ARB_ID_JTAG) ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;

   assign m0_icb_cmd_ready = live & (grant == ARB_ID_CORE) & s_icb_cmd_ready & ~ost_full;
   assign m1_icb_cmd_ready = live & (grant == ARB_ID_JTAG) & s_icb_cmd_ready & ~ost_full;

   assign cmd_hs = s_icb_cmd_valid & s_icb_cmd_ready;

   // Responses follow issue order; with nothing outstanding they are drained and flagged.
   assign head_rsp_ready   = (head == ARB_ID_JTAG) ? m1_icb_rsp_ready : m0_icb_rsp_ready;
   assign s_icb_rsp_ready  = live & (ost_empty | head_rsp_ready);
   assign rsp_hs           = s_icb_rsp_valid & s_icb_rsp_ready;

   assign m0_icb_rsp_valid = live & s_icb_rsp_valid & ~ost_empty & (head == ARB_ID_CORE);
   assign m1_icb_rsp_valid = live & s_icb_rsp_valid & ~ost_empty & (head == ARB_ID_JTAG);
   assign m0_icb_rsp_err   = live & s_icb_rsp_err;
   assign m1_icb_rsp_err   = live & s_icb_rsp_err;
   assign m0_icb_rsp_rdata = live ? s_icb_rsp_rdata : '0;
   assign m1_icb_rsp_rdata = live ? s_icb_rsp_rdata : '0;

   assign arb_err_o = arb_err_q;

   icb_dbg_arb_ost_fifo #(
      .DEPTH     (OST_DEPTH)
   ) u_ost_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (cmd_hs & ~fifo_full),
      .push_id_i (grant),
      .pop_i     (rsp_hs & ~ost_empty),
      .head_o    (head),
      .empty_o   (ost_empty),
      .full_o    (fifo_full),
      .cnt_o     (ost_cnt)
   );

   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      arb_err_d = arb_err_q;
      if (s_icb_cmd_valid && !s_icb_cmd_ready) begin
         lock_d    = 1'b1;
         lock_id_d = grant;
      end else if (cmd_hs) begin
         lock_d    = 1'b0;
      end
      if (rsp_hs && ost_empty) begin
         arb_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_q    <= 1'b0;
         lock_id_q <= ARB_ID_CORE;
         arb_err_q <= 1'b0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         arb_err_q <= arb_err_d;
      end
   end

endmodule

// File: tb/tb_icb_dbg_arb.sv
// Directed bench for icb_dbg_arb: scoreboard queues for slave commands and routed responses.
module tb_icb_dbg_arb;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;

   logic            m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
   logic [AW-1:0]   m0_icb_cmd_addr;
   logic [DW-1:0]   m0_icb_cmd_wdata;
   logic [DW/8-1:0] m0_icb_cmd_wmask;
   logic            m0_icb_rsp_valid, m0_icb_rsp_ready, m0_icb_rsp_err;
   logic [DW-1:0]   m0_icb_rsp_rdata;

   logic            m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
   logic [AW-1:0]   m1_icb_cmd_addr;
   logic [DW-1:0]   m1_icb_cmd_wdata;
   logic [DW/8-1:0] m1_icb_cmd_wmask;
   logic            m1_icb_rsp_valid, m1_icb_rsp_ready, m1_icb_rsp_err;
   logic [DW-1:0]   m1_icb_rsp_rdata;

   logic            s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
   logic [AW-1:0]   s_icb_cmd_addr;
   logic [DW-1:0]   s_icb_cmd_wdata;
   logic [DW/8-1:0] s_icb_cmd_wmask;
   logic            s_icb_rsp_valid, s_icb_rsp_ready, s_icb_rsp_err;
   logic [DW-1:0]   s_icb_rsp_rdata;
   logic            arb_err_o;

   int errors = 0;
   int checks = 0;

   logic [68:0] cmd_q[$];   // {read, wmask, wdata, addr}
   logic [33:0] rsp_q[$];   // {id, err, rdata}

   always #5 clk = ~clk;

   icb_dbg_arb dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .m0_icb_cmd_valid (m0_icb_cmd_valid),
      .m0_icb_cmd_ready (m0_icb_cmd_ready),
      .m0_icb_cmd_addr  (m0_icb_cmd_addr),
      .m0_icb_cmd_read  (m0_icb_cmd_read),
      .m0_icb_cmd_wdata (m0_icb_cmd_wdata),
      .m0_icb_cmd_wmask (m0_icb_cmd_wmask),
      .m0_icb_rsp_valid (m0_icb_rsp_valid),
      .m0_icb_rsp_ready (m0_icb_rsp_ready),
      .m0_icb_rsp_err   (m0_icb_rsp_err),
      .m0_icb_rsp_rdata (m0_icb_rsp_rdata),
      .m1_icb_cmd_valid (m1_icb_cmd_valid),
      .m1_icb_cmd_ready (m1_icb_cmd_ready),
      .m1_icb_cmd_addr  (m1_icb_cmd_addr),
      .m1_icb_cmd_read  (m1_icb_cmd_read),
      .m1_icb_cmd_wdata (m1_icb_cmd_wdata),
      .m1_icb_cmd_wmask (m1_icb_cmd_wmask),
      .m1_icb_rsp_valid (m1_icb_rsp_valid),
      .m1_icb_rsp_ready (m1_icb_rsp_ready),
      .m1_icb_rsp_err   (m1_icb_rsp_err),
      .m1_icb_rsp_rdata (m1_icb_rsp_rdata),
      .s_icb_cmd_valid  (s_icb_cmd_valid),
      .s_icb_cmd_ready  (s_icb_cmd_ready),
      .s_icb_cmd_addr   (s_icb_cmd_addr),
      .s_icb_cmd_read   (s_icb_cmd_read),
      .s_icb_cmd_wdata  (s_icb_cmd_wdata),
      .s_icb_cmd_wmask  (s_icb_cmd_wmask),
      .s_icb_rsp_valid  (s_icb_rsp_valid),
      .s_icb_rsp_ready  (s_icb_rsp_ready),
      .s_icb_rsp_err    (s_icb_rsp_err),
      .s_icb_rsp_rdata  (s_icb_rsp_rdata),
      .arb_err_o        (arb_err_o)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [68:0] rd_cmd(input logic [31:0] addr);
      return {1'b1, 4'h0, 32'h0, addr};
   endfunction

   task automatic check_rsp(input logic id, input logic err, input logic [DW-1:0] rd);
      logic [33:0] e;
      if (rsp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_unexpected: got id=%0b rdata=%0h expected none", id, rd);
      end else begin
         e = rsp_q.pop_front();
         chkw("rsp_route", 128'({id, err, rd}), 128'(e));
      end
   endtask

   // Slave-side command monitor.
   always @(negedge clk) begin
      if (s_icb_cmd_valid && s_icb_cmd_ready) begin
         if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_unexpected: got addr=%0h expected none", s_icb_cmd_addr);
         end else begin
            chkw("slave_cmd",
                 128'({s_icb_cmd_read, s_icb_cmd_wmask, s_icb_cmd_wdata, s_icb_cmd_addr}),
                 128'(cmd_q.pop_front()));
         end
      end
   end

   // Master-side response monitor.
   always @(negedge clk) begin
      if (m0_icb_rsp_valid || m1_icb_rsp_valid) begin
         chk1("rsp_one_hot", m0_icb_rsp_valid & m1_icb_rsp_valid, 1'b0);
      end
      if (m0_icb_rsp_valid && m0_icb_rsp_ready) check_rsp(1'b0, m0_icb_rsp_err, m0_icb_rsp_rdata);
      if (m1_icb_rsp_valid && m1_icb_rsp_ready) check_rsp(1'b1, m1_icb_rsp_err, m1_icb_rsp_rdata);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_m0(input logic v, input logic [31:0] addr);
      m0_icb_cmd_valid = v;
      m0_icb_cmd_addr  = addr;
      m0_icb_cmd_read  = 1'b1;
      m0_icb_cmd_wdata = '0;
      m0_icb_cmd_wmask = '0;
   endtask

   task automatic drv_m1(input logic v, input logic [31:0] addr);
      m1_icb_cmd_valid = v;
      m1_icb_cmd_addr  = addr;
      m1_icb_cmd_read  = 1'b1;
      m1_icb_cmd_wdata = '0;
      m1_icb_cmd_wmask = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drv_m0(1'b0, 32'h0);
      drv_m1(1'b0, 32'h0);
      m0_icb_rsp_ready = 1'b1;
      m1_icb_rsp_ready = 1'b1;
      s_icb_cmd_ready  = 1'b1;
      s_icb_rsp_valid  = 1'b0;
      s_icb_rsp_err    = 1'b0;
      s_icb_rsp_rdata  = '0;

      // Reset values.
      @(negedge clk);
      chk1("rst_s_rsp_ready", s_icb_rsp_ready, 1'b0);
      chk1("rst_m0_cmd_ready", m0_icb_cmd_ready, 1'b0);
      chk1("rst_arb_err", arb_err_o, 1'b0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Priority: both valid, m1 first, then m0.
      drv_m0(1'b1, 32'h100);
      drv_m1(1'b1, 32'h200);
      cmd_q.push_back(rd_cmd(32'h200));
      cmd_q.push_back(rd_cmd(32'h100));
      @(negedge clk);
      chk1("prio_m1_ready", m1_icb_cmd_ready, 1'b1);
      chk1("prio_m0_ready", m0_icb_cmd_ready, 1'b0);
      chkw("prio_addr_first", 128'(s_icb_cmd_addr), 128'(32'h200));
      next_cycle();
      drv_m1(1'b0, 32'h0);
      @(negedge clk);
      chkw("prio_addr_second", 128'(s_icb_cmd_addr), 128'(32'h100));
      chk1("prio_m0_ready2", m0_icb_cmd_ready, 1'b1);
      next_cycle();

      // Full: two outstanding, a write from m0 must wait.
      m0_icb_cmd_valid = 1'b1;
      m0_icb_cmd_addr  = 32'h300;
      m0_icb_cmd_read  = 1'b0;
      m0_icb_cmd_wdata = 32'hCAFE_F00D;
      m0_icb_cmd_wmask = 4'hF;
      @(negedge clk);
      chk1("full_s_valid", s_icb_cmd_valid, 1'b0);
      chk1("full_m0_ready", m0_icb_cmd_ready, 1'b0);
      next_cycle();
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_rdata = 32'hDEAD_BEEF;
      rsp_q.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
      @(negedge clk);
      chk1("full_hold_on_pop", s_icb_cmd_valid, 1'b0);
      chk1("route_m1_valid", m1_icb_rsp_valid, 1'b1);
      chk1("route_m0_quiet", m0_icb_rsp_valid, 1'b0);
      next_cycle();
      s_icb_rsp_rdata = 32'h1234_5678;
      rsp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
      cmd_q.push_back({1'b0, 4'hF, 32'hCAFE_F00D, 32'h300});
      @(negedge clk);
      chk1("full_release_valid", s_icb_cmd_valid, 1'b1);
      chk1("full_release_ready", m0_icb_cmd_ready, 1'b1);
      chk1("route_m0_valid", m0_icb_rsp_valid, 1'b1);
      next_cycle();
      drv_m0(1'b0, 32'h0);
      s_icb_rsp_rdata  = 32'hA5A5_A5A5;
      s_icb_rsp_err    = 1'b1;
      m0_icb_rsp_ready = 1'b0;
      @(negedge clk);
      chk1("rsp_backpressure", s_icb_rsp_ready, 1'b0);
      chk1("err_broadcast", m1_icb_rsp_err, 1'b1);
      chk1("err_not_valid_m1", m1_icb_rsp_valid, 1'b0);
      next_cycle();
      m0_icb_rsp_ready = 1'b1;
      rsp_q.push_back({1'b0, 1'b1, 32'hA5A5_A5A5});
      @(negedge clk);
      chk1("rsp_ready_release", s_icb_rsp_ready, 1'b1);
      next_cycle();
      s_icb_rsp_valid = 1'b0;
      s_icb_rsp_err   = 1'b0;

      // Lock: m0 stalled at 0x40 keeps the grant while m1 shows up.
      s_icb_cmd_ready = 1'b0;
      drv_m0(1'b1, 32'h40);
      cmd_q.push_back(rd_cmd(32'h40));
      cmd_q.push_back(rd_cmd(32'h80));
      @(negedge clk);
      chkw("lock_addr_c1", 128'(s_icb_cmd_addr), 128'(32'h40));
      next_cycle();
      drv_m1(1'b1, 32'h80);
      @(negedge clk);
      chkw("lock_addr_c2", 128'(s_icb_cmd_addr), 128'(32'h40));
      next_cycle();
      @(negedge clk);
      chkw("lock_addr_c3", 128'(s_icb_cmd_addr), 128'(32'h40));
      next_cycle();
      s_icb_cmd_ready = 1'b1;
      @(negedge clk);
      chk1("lock_m0_ready", m0_icb_cmd_ready, 1'b1);
      chk1("lock_m1_ready", m1_icb_cmd_ready, 1'b0);
      next_cycle();
      drv_m0(1'b0, 32'h0);
      @(negedge clk);
      chk1("lock_m1_after", m1_icb_cmd_ready, 1'b1);
      chkw("lock_addr_m1", 128'(s_icb_cmd_addr), 128'(32'h80));
      next_cycle();
      drv_m1(1'b0, 32'h0);
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_rdata = 32'h1111_1111;
      rsp_q.push_back({1'b0, 1'b0, 32'h1111_1111});
      @(negedge clk);
      chk1("order_m0_first", m0_icb_rsp_valid, 1'b1);
      next_cycle();
      s_icb_rsp_rdata = 32'h2222_2222;
      rsp_q.push_back({1'b1, 1'b0, 32'h2222_2222});
      @(negedge clk);
      chk1("order_m1_second", m1_icb_rsp_valid, 1'b1);
      next_cycle();
      s_icb_rsp_valid = 1'b0;

      // Reset mid-transaction: one command outstanding, then reset.
      drv_m0(1'b1, 32'h700);
      cmd_q.push_back(rd_cmd(32'h700));
      @(negedge clk);
      chk1("mid_m0_ready", m0_icb_cmd_ready, 1'b1);
      next_cycle();
      rst_n           = 1'b0;
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_err   = 1'b1;
      s_icb_rsp_rdata = 32'h7777_7777;
      @(negedge clk);
      chk1("mid_rst_s_valid", s_icb_cmd_valid, 1'b0);
      chk1("mid_rst_m0_ready", m0_icb_cmd_ready, 1'b0);
      chk1("mid_rst_s_rsp_ready", s_icb_rsp_ready, 1'b0);
      chk1("mid_rst_m0_rsp_valid", m0_icb_rsp_valid, 1'b0);
      chkw("mid_rst_addr", 128'(s_icb_cmd_addr), 128'(0));
      chkw("mid_rst_rdata", 128'(m0_icb_rsp_rdata), 128'(0));
      next_cycle();
      drv_m0(1'b0, 32'h0);
      rst_n = 1'b1;

      // Orphan response: ID discarded by reset, so nobody gets it.
      @(negedge clk);
      chk1("orphan_m0_valid", m0_icb_rsp_valid, 1'b0);
      chk1("orphan_m1_valid", m1_icb_rsp_valid, 1'b0);
      chk1("orphan_drain_ready", s_icb_rsp_ready, 1'b1);
      chk1("orphan_err_not_yet", arb_err_o, 1'b0);
      next_cycle();
      s_icb_rsp_valid = 1'b0;
      s_icb_rsp_err   = 1'b0;
      @(negedge clk);
      chk1("orphan_err_set", arb_err_o, 1'b1);
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk1("orphan_err_sticky", arb_err_o, 1'b1);
      next_cycle();

`ifdef ICB_ARB_RR_EN
      // Round-robin: both valid, grants alternate 1,0,1,0 starting from reset state.
      drv_m0(1'b1, 32'h500);
      drv_m1(1'b1, 32'h600);
      cmd_q.push_back(rd_cmd(32'h600));
      cmd_q.push_back(rd_cmd(32'h500));
      cmd_q.push_back(rd_cmd(32'h600));
      cmd_q.push_back(rd_cmd(32'h500));
      @(negedge clk);
      chk1("rr_grant_1", m1_icb_cmd_ready, 1'b1);
      next_cycle();
      s_icb_rsp_valid = 1'b1;
      s_icb_rsp_rdata = 32'h0000_0A01;
      rsp_q.push_back({1'b1, 1'b0, 32'h0000_0A01});
      @(negedge clk);
      chk1("rr_grant_2", m0_icb_cmd_ready, 1'b1);
      next_cycle();
      s_icb_rsp_rdata = 32'h0000_0A02;
      rsp_q.push_back({1'b0, 1'b0, 32'h0000_0A02});
      @(negedge clk);
      chk1("rr_grant_3", m1_icb_cmd_ready, 1'b1);
      next_cycle();
      s_icb_rsp_rdata = 32'h0000_0A03;
      rsp_q.push_back({1'b1, 1'b0, 32'h0000_0A03});
      @(negedge clk);
      chk1("rr_grant_4", m0_icb_cmd_ready, 1'b1);
      next_cycle();
      drv_m0(1'b0, 32'h0);
      drv_m1(1'b0, 32'h0);
      s_icb_rsp_rdata = 32'h0000_0A04;
      rsp_q.push_back({1'b0, 1'b0, 32'h0000_0A04});
      next_cycle();
      s_icb_rsp_valid = 1'b0;
      next_cycle();
`endif

      // Sticky error clears only on reset.
      rst_n = 1'b0;
      @(negedge clk);
      chk1("err_cleared_by_rst", arb_err_o, 1'b0);
      chkw("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
      chkw("rsp_q_drained", 128'(rsp_q.size()), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/icb_dbg_arb.md
Name: icb_dbg_arb

Overview:
- 2-to-1 ICB arbiter that shares one memory-side ICB slave port between the core LSU master (m0) and the JTAG debug module master (m1).
- Tracks outstanding commands in an ID FIFO so that each response is returned to the master that issued the matching command.
- Sits between the core/JTAG top-level ICB outputs and the system memory/bus interconnect.

Parameters:
- AW, 32, address width; matches `MemAddrBus.
- DW, 32, data width; matches `MemBus.
- OST_DEPTH, 2, maximum number of outstanding commands; a power of 2, at least 1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- mX_icb_cmd_valid  in  1  command valid (X = 0 core, X = 1 JTAG); the same port group is repeated per master
- mX_icb_cmd_ready  out  1  command accepted
- mX_icb_cmd_addr  in  AW  command address
- mX_icb_cmd_read  in  1  1 = read, 0 = write
- mX_icb_cmd_wdata  in  DW  write data
- mX_icb_cmd_wmask  in  DW/8  byte strobes
- mX_icb_rsp_valid  out  1  response valid to master X
- mX_icb_rsp_ready  in  1  master X can accept a response
- mX_icb_rsp_err  out  1  response error
- mX_icb_rsp_rdata  out  DW  response read data
- s_icb_cmd_valid / ready / addr / read / wdata / wmask  out/in/out/out/out/out  1/1/AW/1/DW/DW/8  slave-side command channel
- s_icb_rsp_valid / ready / err / rdata  in/out/in/in  1/1/1/DW  slave-side response channel
- arb_err_o  out  1  sticky flag: a response arrived with no outstanding command

Behaviour:
Reset values:
- All outputs are 0 during reset.
- Internal state resets to: ost_cnt = 0, FIFO pointers = 0, lock_r = 0, lock_id = 0, rr_last = 0, arb_err_o = 0.
- Reset asserted mid-transaction discards all outstanding IDs. No response is routed afterwards until a new command is accepted.

Command path:
- The command path is purely combinational: zero added latency.
- ost_full = (ost_cnt == OST_DEPTH).
- Grant selection:
  - If lock_r = 1: grant = lock_id.
  - Otherwise: the arbitration policy picks among the valid masters.
  - If no master is valid, grant = 0.
- s_icb_cmd_valid = mGRANT_cmd_valid & ~ost_full.
- All s_icb_cmd_* payload fields are muxed from the granted master.
- mX_icb_cmd_ready = (grant == X) & s_icb_cmd_ready & ~ost_full. The non-granted master sees ready = 0.
- Cmd handshake = s_icb_cmd_valid & s_icb_cmd_ready.

Grant lock:
- Once a command is presented but not accepted, the grant is held so the ICB valid/payload stability rule is not violated by a switch.
- If s_icb_cmd_valid & ~s_icb_cmd_ready: lock_r <= 1 and lock_id <= grant.
- On cmd handshake: lock_r <= 0.

Response path:
- On cmd handshake, push grant into the ID FIFO.
- On rsp handshake (s_icb_rsp_valid & s_icb_rsp_ready), pop the FIFO.
- A simultaneous push and pop leaves ost_cnt unchanged.
- When full, push is blocked; there is no pop-to-push bypass.
- head = FIFO head ID.
- mX_icb_rsp_valid = s_icb_rsp_valid & ~empty & (head == X).
- err and rdata are broadcast to both masters; only the valid qualifies them.
- s_icb_rsp_ready = empty ? 1 : mHEAD_rsp_ready.

Boundary cases:
- s_icb_rsp_valid while the FIFO is empty: the response is drained (ready = 1), no master sees it, and arb_err_o <= 1. arb_err_o is cleared only by reset.
- A response for the head ID and a new command from the other master in the same cycle are both honoured.
- ost_cnt never exceeds OST_DEPTH and never goes below 0. Pointers wrap modulo OST_DEPTH.

Optional Feature:
ICB_ARB_RR_EN selects the arbitration policy.
- Defined: round-robin.
  - rr_last <= grant on each cmd handshake.
  - When both masters are valid and unlocked, the master != rr_last wins.
- Undefined: fixed priority, m1 (JTAG) over m0. rr_last logic is not compiled.

Decomposition:
- Shared package/defines (add to defines.v):
  - ARB_ID_CORE = 1'b0
  - ARB_ID_JTAG = 1'b1
  - `MemAddrBus and `MemBus reused
- Sub-module icb_arb_ost_fifo:
  - Parameterised depth, 1-bit entries.
  - Interface: push, pop, head, empty, full, cnt.
- Arbitration, lock and muxing stay in the top module.

Test Plan:
1. Fixed priority (macro off): m0 and m1 both valid, read addr 0x100/0x200, slave ready = 1 → slave sees 0x200 first; m1_cmd_ready = 1, m0_cmd_ready = 0. Next cycle slave sees 0x100.
2. Lock hold: m0 valid at 0x40 with s_cmd_ready = 0 for 3 cycles, m1 raises valid in cycle 2 → slave addr stays 0x40 until accepted. m1 is granted on the following cycle.
3. Response routing and ordering: OST_DEPTH = 2; m1 cmd then m0 cmd accepted, slave returns rdata 0xDEADBEEF then 0x12345678 → m1 receives 0xDEADBEEF, then m0 receives 0x12345678. rsp_valid is never asserted to the wrong master.
4. Full backpressure: 2 outstanding commands, no responses, m0 valid → s_cmd_valid = 0, m0_cmd_ready = 0. A response pop in cycle N allows acceptance in cycle N+1.
5. Orphan response: empty FIFO, s_rsp_valid = 1 with err = 1 → s_rsp_ready = 1, no mX_rsp_valid, arb_err_o = 1 from the next cycle until rst_n = 0.
6. Round-robin (ICB_ARB_RR_EN defined), both masters continuously valid → grants alternate 1,0,1,0 across 4 handshakes. Reset asserted mid-stream → ost_cnt = 0, all outputs 0.
